// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl -- wait-state data memory controller
//
// Accepts a single read or write request from the control unit while idle,
// inserts WAIT_CYCLES wait states, then performs one access on an internal
// 2**ADDR_W-word storage array and pulses done for one cycle.
//
// Optional feature macro: DMEM_RANGE_CHECK_EN
//   defined   : addresses >= DEPTH complete normally but raise err with done,
//               leave storage and rd_data untouched.
//   undefined : addresses wrap to their low ADDR_W bits, err is always 0.
//
// Ports
//   clock      in   1       system clock, rising-edge active
//   reset      in   1       synchronous, active-high reset
//   mem_read   in   1       read request (sampled only when idle)
//   mem_write  in   1       write request (sampled only when idle, wins over read)
//   addr       in   16      word address
//   wr_data    in   DATA_W  write data
//   rd_data    out  DATA_W  registered read data, changes only on a read access
//   busy       out  1       request in progress
//   done       out  1       one-cycle completion pulse
//   err        out  1       one-cycle out-of-range pulse, coincident with done
// ---------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         DEPTH     = 2**ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [15:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rd_data;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_in_range;
    logic              w_store;
    logic [ADDR_W-1:0] w_idx;

    assign w_req = mem_write | mem_read;
    assign w_idx = r_addr[ADDR_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    assign w_in_range = ((r_addr >> ADDR_W) == 16'd0);
`else
    // Upper address bits are deliberately dropped: accesses wrap around.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |(r_addr >> ADDR_W);
    assign w_in_range       = 1'b1;
`endif

    // Gated by reset so an aborted write can never land in storage.
    assign w_store = (r_state == S_ACCESS) && r_is_write && w_in_range && !reset;

    // NOTE: storage has no reset -- contents must survive reset, and leaving
    // it out lets the array map onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_store) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // NOTE: every register here uses <= so all state advances from the same
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 16'd0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Only sampled here, so requests while busy are dropped
                    // and a request on the done cycle is accepted at once.
                    if (w_req) begin
                        r_addr     <= addr;
                        r_wdata    <= wr_data;
                        r_is_write <= mem_write;
                        r_busy     <= 1'b1;
                        r_cnt      <= WAIT_INIT;
                        r_state    <= (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_is_write && w_in_range) begin
                        r_rd_data <= r_mem[w_idx];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= !w_in_range;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl -- self-checking bench for dmem_ctrl
//
// u_dut  : WAIT_CYCLES=2, checked through a scoreboard of expected
//          (rd_data, err) values popped on every done pulse, plus directed
//          latency / busy / pulse-width checks.
// u_dut0 : WAIT_CYCLES=0, directed back-to-back sequence.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    logic        clock = 1'b0;
    logic        reset;

    logic        d_read, d_write;
    logic [15:0] d_addr, d_wdata;
    logic [15:0] rd_data;
    logic        busy, done, err;

    logic        z_read, z_write;
    logic [15:0] z_addr, z_wdata;
    logic [15:0] z_rd_data;
    logic        z_busy, z_done, z_err;

    always #5 clock = ~clock;

    dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .mem_read (d_read),
        .mem_write(d_write),
        .addr     (d_addr),
        .wr_data  (d_wdata),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clock    (clock),
        .reset    (reset),
        .mem_read (z_read),
        .mem_write(z_write),
        .addr     (z_addr),
        .wr_data  (z_wdata),
        .rd_data  (z_rd_data),
        .busy     (z_busy),
        .done     (z_done),
        .err      (z_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model [256];
    logic [15:0] model_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse of u_dut must match the oldest expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rd_data", 32'(rd_data), 32'(e.data));
                check("sb_err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    // Drive one request at a negedge; returns at the negedge after the
    // accepting edge with request lines dropped.
    task automatic issue(input logic wr, input logic rd, input logic [15:0] a,
                         input logic [15:0] d, input bit push);
        exp_t e;
        if (push) begin
            e.err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
            if (a >= 16'd256) e.err = 1'b1;
`endif
            if (!e.err) begin
                if (wr) model[a[7:0]] = d;
                else    model_rd = model[a[7:0]];
            end
            e.data = model_rd;
            sb_q.push_back(e);
        end
        d_write = wr;
        d_read  = rd;
        d_addr  = a;
        d_wdata = d;
        @(posedge clock);
        @(negedge clock);
        d_write = 1'b0;
        d_read  = 1'b0;
    endtask

    // Wait (bounded) for done; 'remain' is the number of cycles still
    // expected before done, which is also the number of busy cycles left.
    task automatic finish(input string tag, input int remain);
        int n = 0;
        int b = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) b++;
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(remain));
        check({tag, "_busy_cycles"}, 32'(b), 32'(remain));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic txn(input logic wr, input logic rd, input logic [15:0] a,
                       input logic [15:0] d, input string tag);
        issue(wr, rd, a, d, 1'b1);
        finish(tag, 3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        model_rd = 16'h0000;
        d_read = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        z_read = 1'b0; z_write = 1'b0; z_addr = 16'h0; z_wdata = 16'h0;

        // Reset with a write request held high: the request must be ignored.
        reset   = 1'b1;
        d_write = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_z_busy", 32'(z_busy), 32'd0);
        reset   = 1'b0;
        d_write = 1'b0;
        @(negedge clock);
        check("rst_req_ignored", 32'(busy), 32'd0);

        // Basic write then read-back.
        txn(1'b1, 1'b0, 16'h0005, 16'hBEEF, "wr_beef");
        txn(1'b0, 1'b1, 16'h0005, 16'h0000, "rd_beef");
        check("rd_beef_value", 32'(rd_data), 32'h0000BEEF);

        // Write has priority over a simultaneous read.
        txn(1'b1, 1'b1, 16'h0010, 16'h1234, "both_hi");
        check("both_hi_rd_unchanged", 32'(rd_data), 32'h0000BEEF);
        txn(1'b0, 1'b1, 16'h0010, 16'h0000, "rd_1234");
        check("rd_1234_value", 32'(rd_data), 32'h00001234);

        // Requests and address changes while busy are ignored.
        txn(1'b1, 1'b0, 16'h0021, 16'h1111, "pre_21");
        issue(1'b1, 1'b0, 16'h0020, 16'h7777, 1'b1);
        check("busy_during", 32'(busy), 32'd1);
        d_write = 1'b1; d_read = 1'b1; d_addr = 16'h0021; d_wdata = 16'h9999;
        @(negedge clock);
        d_write = 1'b0; d_read = 1'b0;
        finish("busy_ign", 2);
        repeat (4) @(negedge clock);
        txn(1'b0, 1'b1, 16'h0020, 16'h0000, "rd_20");
        check("rd_20_value", 32'(rd_data), 32'h00007777);
        txn(1'b0, 1'b1, 16'h0021, 16'h0000, "rd_21");
        check("rd_21_value", 32'(rd_data), 32'h00001111);

        // Reset in the WAIT state of a write aborts it.
        txn(1'b1, 1'b0, 16'h0003, 16'h00AA, "wr_aa");
        issue(1'b1, 1'b0, 16'h0003, 16'h0055, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_rd_data", 32'(rd_data), 32'd0);
        reset    = 1'b0;
        model_rd = 16'h0000;
        repeat (5) @(negedge clock);
        txn(1'b0, 1'b1, 16'h0003, 16'h0000, "rd_aa");
        check("rd_aa_value", 32'(rd_data), 32'h000000AA);

        // Out-of-range address: wraps by default, flagged with range check.
        txn(1'b1, 1'b0, 16'h0000, 16'h0F0F, "wr_0");
        txn(1'b1, 1'b0, 16'h0100, 16'hC0DE, "wr_100");
        txn(1'b0, 1'b1, 16'h0000, 16'h0000, "rd_0");
`ifdef DMEM_RANGE_CHECK_EN
        check("rd_0_value", 32'(rd_data), 32'h00000F0F);
`else
        check("rd_0_value", 32'(rd_data), 32'h0000C0DE);
`endif
        txn(1'b0, 1'b1, 16'h0105, 16'h0000, "rd_105");

        // WAIT_CYCLES=0: one-edge latency and back-to-back acceptance.
        z_write = 1'b1; z_addr = 16'h0007; z_wdata = 16'hABCD;
        @(negedge clock);
        check("z0_busy", 32'(z_busy), 32'd1);
        check("z0_done_early", 32'(z_done), 32'd0);
        z_write = 1'b0; z_read = 1'b1; z_wdata = 16'h0000;
        @(negedge clock);
        check("z0_wr_done", 32'(z_done), 32'd1);
        check("z0_wr_busy", 32'(z_busy), 32'd0);
        check("z0_wr_rd_unchanged", 32'(z_rd_data), 32'd0);
        @(negedge clock);
        check("z0_b2b_accept", 32'(z_busy), 32'd1);
        check("z0_b2b_done_low", 32'(z_done), 32'd0);
        z_read = 1'b0;
        @(negedge clock);
        check("z0_rd_done", 32'(z_done), 32'd1);
        check("z0_rd_data", 32'(z_rd_data), 32'h0000ABCD);
        check("z0_rd_err", 32'(z_err), 32'd0);
        @(negedge clock);
        check("z0_done_one_cycle", 32'(z_done), 32'd0);
        check("z0_idle", 32'(z_busy), 32'd0);

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 8, internal storage address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted before each access (0..15).
REQ-004 clock  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_read  input  1  read request from control unit, sampled only in IDLE.
REQ-007 mem_write  input  1  write request from control unit, sampled only in IDLE.
REQ-008 addr  input  16  word address from address register.
REQ-009 wr_data  input  DATA_W  write data from memory data register outbound port.
REQ-010 rd_data  output  DATA_W  registered read data to memory data register inbound port.
REQ-011 busy  output  1  high while a request is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle out-of-range pulse, coincident with done (DMEM_RANGE_CHECK_EN only; tied 0 otherwise).

Function
REQ-014 States SHALL be IDLE, WAIT, ACCESS; encoding free.
REQ-015 IDLE: on edge with mem_write=1 or mem_read=1, SHALL latch addr, wr_data, operation; set busy=1; load wait counter with WAIT_CYCLES; go WAIT (or ACCESS if WAIT_CYCLES=0).
REQ-016 mem_write and mem_read both high in IDLE: write SHALL take priority; read discarded.
REQ-017 WAIT: counter decrements each edge; on edge where counter is 1, go ACCESS.
REQ-018 ACCESS: one edge; write stores latched data to storage[latched addr]; read loads rd_data from storage[latched addr]; done=1 and busy=0 after this edge; go IDLE.
REQ-019 Latency: request sampled at edge E0 -> done high in the cycle after edge E0+WAIT_CYCLES+1; done high exactly one cycle.
REQ-020 Requests while busy=1 SHALL be ignored (not queued); addr/wr_data changes while busy SHALL NOT affect the access in progress.
REQ-021 A new request MAY be sampled on the same edge done is high (back-to-back, one idle cycle minimum between ACCESS and next accept is not required).
REQ-022 rd_data SHALL hold its value except on a read ACCESS; writes never modify rd_data.
REQ-023 Read of a location written by an immediately preceding write SHALL return the new data.
REQ-024 Storage contents are not initialized; a read of a never-written location returns unspecified data.

Reset
REQ-025 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, err=0, rd_data=0, counter=0.
REQ-026 Reset mid-operation SHALL abort the request; a pending write SHALL NOT reach storage.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 Requests asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-029 Macro DMEM_RANGE_CHECK_EN defined: latched addr >= DEPTH SHALL complete with normal latency, done=1 and err=1, no storage write, rd_data unchanged.
REQ-030 Macro DMEM_RANGE_CHECK_EN undefined: addr SHALL be truncated to its low ADDR_W bits (wrap-around); err constant 0.

Verification
REQ-031 Reset, WAIT_CYCLES=2: write addr=0x0005 data=0xBEEF -> busy 3 cycles, done one pulse after edge E0+3; then read 0x0005 -> rd_data=0xBEEF.
REQ-032 Both mem_read and mem_write high, addr=0x0010, wr_data=0x1234 -> write performed, rd_data unchanged; subsequent read 0x0010 returns 0x1234.
REQ-033 Second request and addr change during busy -> ignored; only one done pulse; data at original addr.
REQ-034 Write 0x00AA to 0x0003, then reset asserted in WAIT of write 0x0055 to 0x0003 -> outputs zero next cycle; read 0x0003 returns 0x00AA.
REQ-035 With DMEM_RANGE_CHECK_EN: write 0x0100 (ADDR_W=8) -> done=1, err=1, storage[0] unchanged; without macro: same write lands in storage[0x00], err=0.
REQ-036 WAIT_CYCLES=0: read request -> done in cycle after edge E0+1; back-to-back requests on done cycle accepted.
